// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memory_arbiter_pkg;

  // Addresses below this boundary are ROM (read-only); at and above it is RAM.
  localparam logic [31:0] ROM_RAM_SEPARATOR = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFETCH = 1'b0,
    OWN_DATA   = 1'b1
  } owner_t;

  // A word access is legal when aligned and not a store into the ROM region.
  function automatic logic access_legal(input logic [1:0] addr_lsb,
                                        input logic       we,
                                        input logic       below_sep);
    return (addr_lsb == 2'b00) && !(we && below_sep);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
//
// Handshake: a requester raises req with addr/wdata/we and holds them stable
// until gnt is seen high in the same cycle; the transfer is accepted on that
// clock edge. Exactly two cycles later valid pulses for one cycle with rdata
// and err; rdata/err then hold until the next response of the same port.
// req may be raised again in the cycle following valid.
interface memory_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ifetch_req_i;
  logic [DATA_WIDTH-1:0] ifetch_addr_i;
  logic                  ifetch_gnt_o;
  logic                  ifetch_valid_o;
  logic [DATA_WIDTH-1:0] ifetch_rdata_o;
  logic                  ifetch_err_o;

  logic                  data_req_i;
  logic                  data_we_i;
  logic [DATA_WIDTH-1:0] data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_valid_o;
  logic [DATA_WIDTH-1:0] data_rdata_o;
  logic                  data_err_o;

  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  ifetch_req_i, ifetch_addr_i,
    output ifetch_gnt_o, ifetch_valid_o, ifetch_rdata_o, ifetch_err_o,
    input  data_req_i, data_we_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_valid_o, data_rdata_o, data_err_o,
    output mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Requesters plus memory system side.
  modport master (
    output ifetch_req_i, ifetch_addr_i,
    input  ifetch_gnt_o, ifetch_valid_o, ifetch_rdata_o, ifetch_err_o,
    output data_req_i, data_we_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_valid_o, data_rdata_o, data_err_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// is granted. req[0]/gnt[0] is ifetch, req[1]/gnt[1] is data.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 when req[1] won the most recent grant; reset value favours req[1] next.
  logic last_one;

  // One-hot grant, only while enabled.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) begin
        gnt = last_one ? 2'b01 : 2'b10;
      end else if (req[0]) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  // Pointer moves only when a grant is actually issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_one <= 1'b0;
    end else if (|gnt) begin
      last_one <= gnt[1];
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares a single-port ROM/RAM between instruction fetch and data ports.
// Every access is a fixed IDLE -> ACCESS -> RESP sequence; illegal data
// accesses never write memory and return err with zero data.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SEPARATOR  = ROM_RAM_SEPARATOR
) (
  input  logic                    clk,
  input  logic                    reset,
  memory_arbiter_if.slave         bus,
  output state_t                  dbg_state
);

  state_t                state;
  state_t                state_next;
  owner_t                owner_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] ifetch_rdata_q;
  logic [DATA_WIDTH-1:0] data_rdata_q;
  logic                  ifetch_err_q;
  logic                  data_err_q;
  logic                  arb_en;
  logic [1:0]            gnt;
  logic                  legal;

  // Grants only in IDLE; also forced low while reset is asserted.
  assign arb_en = (state == IDLE) && reset;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({bus.data_req_i, bus.ifetch_req_i}),
    .gnt   (gnt)
  );

  assign legal = access_legal(addr_q[1:0], we_q, (addr_q < SEPARATOR));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: fixed three-cycle sequence once a grant is issued.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|gnt) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request on the granting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_IFETCH;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if ((state == IDLE) && (|gnt)) begin
      if (gnt[1]) begin
        owner_q <= OWN_DATA;
        addr_q  <= bus.data_addr_i;
        we_q    <= bus.data_we_i;
        wdata_q <= bus.data_wdata_i;
      end else begin
        owner_q <= OWN_IFETCH;
        addr_q  <= bus.ifetch_addr_i;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  // Capture read data and legality at the end of ACCESS into the owner's port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifetch_rdata_q <= '0;
      ifetch_err_q   <= 1'b0;
      data_rdata_q   <= '0;
      data_err_q     <= 1'b0;
    end else if (state == ACCESS) begin
      if (owner_q == OWN_DATA) begin
        data_rdata_q <= legal ? bus.mem_rdata_i : '0;
        data_err_q   <= !legal;
      end else begin
        ifetch_rdata_q <= legal ? bus.mem_rdata_i : '0;
        ifetch_err_q   <= !legal;
      end
    end
  end

  assign bus.ifetch_gnt_o   = gnt[0];
  assign bus.data_gnt_o     = gnt[1];
  assign bus.ifetch_valid_o = (state == RESP) && (owner_q == OWN_IFETCH);
  assign bus.data_valid_o   = (state == RESP) && (owner_q == OWN_DATA);
  assign bus.ifetch_rdata_o = ifetch_rdata_q;
  assign bus.ifetch_err_o   = ifetch_err_q;
  assign bus.data_rdata_o   = data_rdata_q;
  assign bus.data_err_o     = data_err_q;

  assign bus.mem_we_o    = (state == ACCESS) && we_q && legal;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

  assign dbg_state = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized checks of memory_arbiter against a transaction-level
// model: round-robin winner, legality rules and a word-addressed memory image.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam logic [31:0] SEP = 32'h1000_0000;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;
  int     checks = 0;
  int     failures = 0;

  memory_arbiter_if #(.DATA_WIDTH(32)) bus ();

  memory_arbiter #(.DATA_WIDTH(32), .SEPARATOR(SEP)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory system: 64 ROM words at 0x0, 64 RAM words at SEP, combinational read.
  logic [31:0] rom [64];
  logic [31:0] ram [64];
  logic [31:0] rom_init [64];
  logic [31:0] ram_init [64];
  logic        mem_loaded = 1'b0;

  assign bus.mem_rdata_i = (bus.mem_addr_o >= SEP) ? ram[bus.mem_addr_o[7:2]]
                                                   : rom[bus.mem_addr_o[7:2]];

  // Preload on the first edge, then apply writes (to either region).
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) begin
        rom[i] <= rom_init[i];
        ram[i] <= ram_init[i];
      end
      mem_loaded <= 1'b1;
    end else if (bus.mem_we_o) begin
      if (bus.mem_addr_o >= SEP) ram[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
      else                       rom[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
    end
  end

  // Reference model state.
  logic [31:0] model_mem [logic [29:0]];
  bit          model_last_data;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_mem.exists(a[31:2])) return model_mem[a[31:2]];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    logic [31:0] idx;
    logic [31:0] mis;
    base = ($urandom_range(0, 1) == 1) ? SEP : 32'h0;
    idx  = 32'($urandom_range(0, 63));
    mis  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
    return base | (idx << 2) | mis;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   32'({bus.ifetch_gnt_o, bus.data_gnt_o}), 32'h0);
    check({tag, "_valid"}, 32'({bus.ifetch_valid_o, bus.data_valid_o}), 32'h0);
    check({tag, "_err"},   32'({bus.ifetch_err_o, bus.data_err_o}), 32'h0);
    check({tag, "_we"},    32'(bus.mem_we_o), 32'h0);
    check({tag, "_addr"},  bus.mem_addr_o, 32'h0);
    check({tag, "_wdata"}, bus.mem_wdata_o, 32'h0);
    check({tag, "_irdata"}, bus.ifetch_rdata_o, 32'h0);
    check({tag, "_drdata"}, bus.data_rdata_o, 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // One full transaction starting in IDLE; inputs are already applied.
  // With hold set the winner keeps its request asserted afterwards.
  task automatic txn(input bit hold);
    bit          win_data;
    bit          we;
    bit          legal;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    @(negedge clk);
    if (bus.ifetch_req_i && bus.data_req_i) win_data = !model_last_data;
    else                                    win_data = bus.data_req_i;
    check("gnt_ifetch", 32'(bus.ifetch_gnt_o), 32'(!win_data));
    check("gnt_data",   32'(bus.data_gnt_o),   32'(win_data));
    check("idle_we",    32'(bus.mem_we_o), 32'h0);
    a      = win_data ? bus.data_addr_i : bus.ifetch_addr_i;
    we     = win_data && bus.data_we_i;
    wd     = bus.data_wdata_i;
    legal  = (a[1:0] == 2'b00) && !(we && (a < SEP));
    exp_rd = legal ? model_read(a) : 32'h0;
    model_last_data = win_data;
    @(posedge clk);
    #1;
    if (!hold) begin
      if (win_data) bus.data_req_i = 1'b0;
      else          bus.ifetch_req_i = 1'b0;
    end
    @(negedge clk);
    check("acc_gnt",   32'({bus.ifetch_gnt_o, bus.data_gnt_o}), 32'h0);
    check("acc_valid", 32'({bus.ifetch_valid_o, bus.data_valid_o}), 32'h0);
    check("acc_we",    32'(bus.mem_we_o), 32'(we && legal));
    check("acc_addr",  bus.mem_addr_o, a);
    if (we) check("acc_wdata", bus.mem_wdata_o, wd);
    @(negedge clk);
    check("resp_valid", 32'({bus.ifetch_valid_o, bus.data_valid_o}), 32'({!win_data, win_data}));
    check("resp_gnt",   32'({bus.ifetch_gnt_o, bus.data_gnt_o}), 32'h0);
    check("resp_we",    32'(bus.mem_we_o), 32'h0);
    if (win_data) begin
      check("resp_drdata", bus.data_rdata_o, exp_rd);
      check("resp_derr",   32'(bus.data_err_o), 32'(!legal));
    end else begin
      check("resp_irdata", bus.ifetch_rdata_o, exp_rd);
      check("resp_ierr",   32'(bus.ifetch_err_o), 32'(!legal));
    end
    if (we && legal) model_mem[a[31:2]] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = we;
    bus.data_addr_i  = a;
    bus.data_wdata_i = wd;
  endtask

  task automatic set_ifetch(input logic [31:0] a);
    bus.ifetch_req_i  = 1'b1;
    bus.ifetch_addr_i = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_pulse");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_last_data = 1'b0;
  endtask

  // Directed steps followed by randomized traffic.
  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_init[i] = $urandom;
      ram_init[i] = $urandom;
    end
    ram_init[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 64; i++) begin
      model_mem[30'(i)]                  = rom_init[i];
      model_mem[30'((SEP >> 2) + 32'(i))] = ram_init[i];
    end
    model_last_data   = 1'b0;
    reset             = 1'b0;
    bus.ifetch_req_i  = 1'b1;
    bus.ifetch_addr_i = 32'h0;
    bus.data_req_i    = 1'b1;
    bus.data_we_i     = 1'b0;
    bus.data_addr_i   = 32'h0;
    bus.data_wdata_i  = 32'h0;

    // Reset values, with both requests high to show grants are suppressed.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    bus.ifetch_req_i = 1'b0;
    bus.data_req_i   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Load of a preloaded RAM word.
    set_data(1'b0, 32'h1000_0010, 32'h0);
    txn(1'b0);
    check("load_deadbeef", bus.data_rdata_o, 32'hDEAD_BEEF);

    // Store then load back.
    set_data(1'b1, 32'h1000_0020, 32'h1234_5678);
    txn(1'b0);
    check("store_ram", ram[8], 32'h1234_5678);
    set_data(1'b0, 32'h1000_0020, 32'h0);
    txn(1'b0);
    check("load_back", bus.data_rdata_o, 32'h1234_5678);

    // Store into ROM is blocked; ROM content unchanged.
    set_data(1'b1, 32'h0000_0040, 32'hBAD0_BAD0);
    txn(1'b0);
    check("rom_store_err", 32'({bus.data_err_o}), 32'h1);
    check("rom_store_mem", rom[16], rom_init[16]);
    set_data(1'b0, 32'h0000_0040, 32'h0);
    txn(1'b0);

    // Misaligned fetch.
    set_ifetch(32'h0000_0006);
    txn(1'b0);
    check("misaligned_err", 32'(bus.ifetch_err_o), 32'h1);

    // Reset during ACCESS of a RAM store.
    set_data(1'b1, 32'h1000_0030, 32'hCAFE_F00D);
    @(negedge clk);
    check("rst_gnt", 32'(bus.data_gnt_o), 32'h1);
    @(posedge clk);
    #1;
    bus.data_req_i = 1'b0;
    @(negedge clk);
    check("rst_pre_we", 32'(bus.mem_we_o), 32'h1);
    reset = 1'b0;
    set_data(1'b0, 32'h1000_0030, 32'h0);
    set_ifetch(32'h0000_0004);
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    check("rst_nowrite", ram[12], ram_init[12]);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_last_data = 1'b0;
    txn(1'b0);
    check("rst_tie_data", 32'(bus.data_valid_o), 32'h0);
    txn(1'b0);

    // Both requesters continuously asserted from reset.
    do_reset();
    set_ifetch(32'h0000_0010);
    set_data(1'b0, 32'h1000_0010, 32'h0);
    for (int k = 0; k < 4; k++) txn(1'b1);
    bus.ifetch_req_i = 1'b0;
    bus.data_req_i   = 1'b0;

    // Randomized traffic; a losing requester keeps its request pending.
    for (int t = 0; t < 30; t++) begin
      if (!bus.ifetch_req_i && ($urandom_range(0, 2) != 0)) set_ifetch(rand_addr());
      if (!bus.data_req_i && ($urandom_range(0, 2) != 0))
        set_data(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (!bus.ifetch_req_i && !bus.data_req_i) set_data(1'b0, rand_addr(), 32'h0);
      txn(1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      if (bus.ifetch_req_i || bus.data_req_i) txn(1'b0);
    end

    // No requests: remain idle with no grants.
    repeat (3) @(negedge clk);
    check("idle_state", 32'(dbg_state), 32'(IDLE));
    check("idle_gnt", 32'({bus.ifetch_gnt_o, bus.data_gnt_o}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and sequencer in front of the single-port memory system (ROM below `0x1000_0000`, RAM at and above it). It shares that memory between an instruction-fetch requester and a data load/store requester using round-robin on ties. Each access is registered and sequenced as a fixed 3-cycle transaction. Illegal data accesses (misaligned, or writes into the ROM region) are blocked and reported.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of address, write data and read data
- `SEPARATOR`, `32'h1000_0000`, ROM/RAM boundary; addresses below it are read-only

Ports:
- `clk` input 1: rising-edge clock
- `reset` input 1: asynchronous, active-low reset
- `ifetch_req_i` input 1: instruction read request
- `ifetch_addr_i` input DATA_WIDTH: instruction byte address
- `ifetch_gnt_o` output 1: request accepted this cycle
- `ifetch_valid_o` output 1: one-cycle response strobe
- `ifetch_rdata_o` output DATA_WIDTH: fetched word, valid with strobe
- `ifetch_err_o` output 1: misaligned fetch, valid with strobe
- `data_req_i` input 1: data request
- `data_we_i` input 1: 1 = store, 0 = load
- `data_addr_i` input DATA_WIDTH: data byte address
- `data_wdata_i` input DATA_WIDTH: store data
- `data_gnt_o` output 1: request accepted this cycle
- `data_valid_o` output 1: one-cycle response strobe
- `data_rdata_o` output DATA_WIDTH: load data, valid with strobe
- `data_err_o` output 1: misaligned access or ROM store, valid with strobe
- `mem_we_o` output 1: to memory system `Write_Enable_i`
- `mem_addr_o` output DATA_WIDTH: to memory system `Address_i`
- `mem_wdata_o` output DATA_WIDTH: to memory system `Write_Data_i`
- `mem_rdata_i` input DATA_WIDTH: from memory system `Data_o`, combinational read

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `*_gnt_o` is combinational.
  - Only one requester asserting: that requester is granted.
  - Both asserting: the requester that was not granted last wins.
  - On the granting edge, latch the owner, address, `we` and wdata, then go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - `mem_addr_o` and `mem_wdata_o` are driven from the latched registers.
  - `mem_we_o` = latched `we` AND legal.
  - At the end of the cycle, capture `mem_rdata_i` into the response register (zero if illegal), then go to RESP.
- RESP:
  - Assert the owner's `*_valid_o` and `*_err_o` for exactly one cycle, then go to IDLE.
  - No grants are issued in RESP.
- Legality:
  - Any access with `addr[1:0] != 0` is illegal.
  - A data store with `addr < SEPARATOR` is illegal.
  - Instruction fetches are never stores.
- Requesters hold `req`, addr and wdata stable until `gnt`. They may re-assert `req` immediately after `valid`.
- The round-robin pointer updates only on a grant.

## Timing
- A request sampled in IDLE at cycle N gives: `gnt` in cycle N, ACCESS in N+1, `valid` in N+2.
- A new grant is possible in N+3 at the earliest, so peak throughput is one access per 3 cycles.
- Store: `mem_we_o` is high for exactly one cycle (ACCESS). The RAM write occurs on the edge ending ACCESS.
- `rdata_o` and `err_o` hold their value until the next response of the same port. They are meaningful only with `valid_o`.
- Reset values:
  - State is IDLE.
  - All `gnt`, `valid`, `err` and `mem_we_o` outputs are 0.
  - `mem_addr_o`, `mem_wdata_o` and both `rdata_o` are 0.
  - The round-robin pointer is "last = ifetch", so the first tie goes to data.
- Reset asserted mid-ACCESS: `mem_we_o` drops immediately (asynchronous), no write happens, and no `valid` is issued for the aborted transaction.
- `mem_addr_o` holds its last value in IDLE and RESP. `mem_we_o` is 0 outside ACCESS.

## Structure
- Package `memory_arbiter_pkg`:
  - `state_t` enum (IDLE, ACCESS, RESP)
  - `owner_t` enum (OWN_IFETCH, OWN_DATA)
  - `ROM_RAM_SEPARATOR` constant
- Sub-module `rr_arbiter2`:
  - Inputs: two requests, enable, clk/reset.
  - Outputs: one-hot grant.
  - Holds the last-winner flop and updates it only when a grant is issued.

## Test plan
- Data load only, addr `0x1000_0010` preloaded with `0xDEADBEEF`: `data_gnt_o` in cycle N, `data_valid_o` in N+2 with rdata `0xDEADBEEF` and err 0.
- Data store of `0x12345678` to `0x1000_0020`, then a load of the same address: `mem_we_o` is high for exactly one cycle and the load returns `0x12345678`.
- Both requesters asserted continuously from reset: grants alternate data, ifetch, data, ifetch, one every 3 cycles.
- Store to `0x0000_0040` (ROM): `mem_we_o` stays 0, `data_valid_o` with `data_err_o` = 1 and rdata 0; a following ROM read is unchanged.
- Fetch from `0x0000_0006` (misaligned): `ifetch_err_o` = 1 with valid, and no memory write.
- `reset` asserted low during ACCESS of a store to `0x1000_0030`: no write, no valid strobe, all outputs return to reset values, and the first post-reset tie goes to data.
